// File: rtl/sum_diff_decoder.sv
// sum_diff_decoder
//   Recovers an operand pair (A, B) from its exact sum and difference
//   (SUM = A + B, DIFF = A - B). The datapath is a two-stage elastic pipeline
//   with a valid/ready handshake on each side. Words that no valid (A, B) pair
//   could have produced are flagged with ERR, and a saturating counter tracks
//   how many errored words have been delivered downstream.
//
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   IN_VALID   SUM/DIFF word offered
//   IN_READY   decoder accepts a word this cycle (combinational from OUT_READY)
//   SUM        unsigned A+B, NBITS+1 bits
//   DIFF       two's-complement A-B, NBITS+1 bits
//   OUT_VALID  decoded word present
//   OUT_READY  downstream accepts the word this cycle
//   A, B       recovered operands (driven even when ERR = 1)
//   ERR        parity or range inconsistency
//   ERR_COUNT  saturating count of errored words delivered
module sum_diff_decoder #(
  parameter int NBITS    = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [NBITS:0]      SUM,
  input  logic [NBITS:0]      DIFF,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [NBITS-1:0]    A,
  output logic [NBITS-1:0]    B,
  output logic                ERR,
  output logic [CNT_BITS-1:0] ERR_COUNT
);

  localparam int MAX_I = (2 ** (NBITS + 1)) - 2;
  localparam logic signed [NBITS+1:0] MAX_V = MAX_I[NBITS+1:0];
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic                     s1_valid;
  logic [NBITS:0]           s1_sum;
  logic signed [NBITS+1:0]  s1_diff;

  logic                     s2_load;
  logic                     s1_ready;
  logic                     in_xfer;
  logic                     out_xfer;

  logic signed [NBITS+1:0]  sum_ext;
  logic signed [NBITS+1:0]  af;
  logic signed [NBITS+1:0]  bf;
  logic                     parity_err;
  logic                     range_err;

  // Elastic control: S2 takes S1 whenever it is empty or being drained,
  // and S1 accepts whenever it is empty or being moved into S2.
  assign s2_load  = s1_valid && (!OUT_VALID || OUT_READY);
  assign s1_ready = !s1_valid || s2_load;
  assign IN_READY = !RST && s1_ready;
  assign in_xfer  = IN_VALID && IN_READY;
  assign out_xfer = OUT_VALID && OUT_READY;

  // Sums can exceed the signed range and wrap negative; every such wrap lands
  // below zero, so the sign test still catches it as a range error.
  assign sum_ext    = $signed({1'b0, s1_sum});
  assign af         = sum_ext + s1_diff;
  assign bf         = sum_ext - s1_diff;
  assign parity_err = s1_sum[0] != s1_diff[0];
  assign range_err  = af[NBITS+1] || (af > MAX_V) || bf[NBITS+1] || (bf > MAX_V);

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_diff  <= '0;
    end else if (s1_ready) begin
      s1_valid <= IN_VALID;
      if (in_xfer) begin
        s1_sum  <= SUM;
        s1_diff <= {DIFF[NBITS], DIFF};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      A         <= '0;
      B         <= '0;
      ERR       <= 1'b0;
    end else if (s2_load) begin
      OUT_VALID <= 1'b1;
      A         <= af[NBITS:1];
      B         <= bf[NBITS:1];
      ERR       <= parity_err || range_err;
    end else if (out_xfer) begin
      OUT_VALID <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_COUNT <= '0;
    end else if (out_xfer && ERR && (ERR_COUNT != CNT_MAX)) begin
      ERR_COUNT <= ERR_COUNT + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_sum_diff_decoder.sv
module tb_sum_diff_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  sum;
  logic [8:0]  diff;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        err;
  logic [15:0] err_count;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [8:0]  s_sum;
  logic [8:0]  s_diff;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_a;
  logic [7:0]  s_b;
  logic        s_err;
  logic [1:0]  s_err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_diff_decoder #(.NBITS(8), .CNT_BITS(16)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .SUM(sum), .DIFF(diff), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .A(a), .B(b), .ERR(err), .ERR_COUNT(err_count)
  );

  sum_diff_decoder #(.NBITS(8), .CNT_BITS(2)) dut_sat (
    .CLK(clk), .RST(rst), .IN_VALID(s_in_valid), .IN_READY(s_in_ready),
    .SUM(s_sum), .DIFF(s_diff), .OUT_VALID(s_out_valid), .OUT_READY(s_out_ready),
    .A(s_a), .B(s_b), .ERR(s_err), .ERR_COUNT(s_err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_a [10];
  int exp_b [10];
  int sent;
  int recv;
  logic stall;

  initial begin
    rst = 1'b1; in_valid = 1'b0; sum = '0; diff = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_sum = '0; s_diff = '0; s_out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_a", 32'(a), 0);
    check("rst_b", 32'(b), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Basic decode: A=200, B=55
    in_valid = 1'b1; sum = 9'h0FF; diff = 9'h091;
    tick();
    in_valid = 1'b0;
    check("basic_latency_not_yet", 32'(out_valid), 0);
    tick();
    check("basic_out_valid", 32'(out_valid), 1);
    check("basic_a", 32'(a), 200);
    check("basic_b", 32'(b), 55);
    check("basic_err", 32'(err), 0);
    check("basic_err_count", 32'(err_count), 0);

    // Negative difference, then the A=B=255 corner, back to back
    in_valid = 1'b1; sum = 9'h104; diff = 9'h110;
    tick();
    sum = 9'h1FE; diff = 9'h000;
    tick();
    in_valid = 1'b0;
    check("neg_a", 32'(a), 10);
    check("neg_b", 32'(b), 250);
    check("neg_err", 32'(err), 0);
    tick();
    check("max_a", 32'(a), 255);
    check("max_b", 32'(b), 255);
    check("max_err", 32'(err), 0);
    tick();
    check("drain_out_valid", 32'(out_valid), 0);

    // Error words: parity, then BF = -2
    in_valid = 1'b1; sum = 9'h003; diff = 9'h000;
    tick();
    sum = 9'h000; diff = 9'h002;
    tick();
    in_valid = 1'b0;
    check("parity_err", 32'(err), 1);
    check("parity_err_count_before", 32'(err_count), 0);
    tick();
    check("range_err", 32'(err), 1);
    check("range_err_count_mid", 32'(err_count), 1);
    tick();
    check("err_count_two", 32'(err_count), 2);
    check("err_drain_out_valid", 32'(out_valid), 0);

    // Backpressure: 10 words, OUT_READY low for cycles 4..8
    for (int i = 0; i < 10; i++) begin
      exp_a[i] = 10 * i + 1;
      exp_b[i] = 5 * i + 2;
    end
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      stall = (cyc >= 4) && (cyc <= 8);
      out_ready = !stall;
      in_valid = (sent < 10);
      if (sent < 10) begin
        sum  = 9'(exp_a[sent] + exp_b[sent]);
        diff = 9'(exp_a[sent] - exp_b[sent]);
      end
      #1;
      if (stall) begin
        check("bp_in_ready_full", 32'(in_ready), 0);
        check("bp_hold_valid", 32'(out_valid), 1);
        check("bp_hold_a", 32'(a), 32'(exp_a[recv]));
        check("bp_hold_b", 32'(b), 32'(exp_b[recv]));
      end else if (cyc >= 2 && recv < 10) begin
        check("bp_throughput", 32'(out_valid), 1);
      end
      if (cyc == 9) check("bp_release_in_ready", 32'(in_ready), 1);
      if (out_valid && out_ready && recv < 10) begin
        check("bp_order_a", 32'(a), 32'(exp_a[recv]));
        check("bp_order_b", 32'(b), 32'(exp_b[recv]));
        check("bp_order_err", 32'(err), 0);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_all_sent", 32'(sent), 10);
    check("bp_all_received", 32'(recv), 10);
    check("bp_no_duplicate", 32'(out_valid), 0);

    // Reset with two words in flight
    check("pre_reset_err_count", 32'(err_count), 2);
    out_ready = 1'b0;
    in_valid = 1'b1; sum = 9'h003; diff = 9'h000;
    tick();
    sum = 9'h005; diff = 9'h002;
    tick();
    in_valid = 1'b0;
    check("inflight_full_in_ready", 32'(in_ready), 0);
    rst = 1'b1;
    #1;
    check("reset_in_ready_low", 32'(in_ready), 0);
    tick();
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_err_count", 32'(err_count), 0);
    check("reset_in_ready_held", 32'(in_ready), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("after_reset_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; sum = 9'h0FF; diff = 9'h091;
    tick();
    in_valid = 1'b0;
    check("after_reset_latency", 32'(out_valid), 0);
    tick();
    check("after_reset_valid", 32'(out_valid), 1);
    check("after_reset_a", 32'(a), 200);
    check("after_reset_b", 32'(b), 55);
    check("after_reset_err", 32'(err), 0);
    tick();
    check("after_reset_flushed", 32'(out_valid), 0);

    // Counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_sum = 9'h003; s_diff = 9'h000;
      tick();
      check("sat_count_step", 32'(s_err_count), 32'((i < 2) ? 0 : i - 1));
    end
    s_in_valid = 1'b0;
    tick();
    check("sat_hold_4", 32'(s_err_count), 3);
    tick();
    check("sat_hold_5", 32'(s_err_count), 3);
    check("sat_drained", 32'(s_out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
